// File: rtl/multicycle_controller.sv
// ----------------------------------------------------------------------------
// multicycle_controller
//
// This is the main control FSM for the multicycle RV32I core. Each instruction
// takes 3-5 cycles, plus one cycle for every memory wait. The FSM sequences the
// shared ALU, the register file, the memory port and the PC. Outputs are
// combinational from the current state and the inputs. An illegal instruction
// parks the FSM in TRAP, and only Reset leaves that state.
//
// Ports
//   CLK         in   1  clock; all state updates on the rising edge
//   Reset       in   1  synchronous, active-high
//   op          in   7  instruction[6:0]
//   funct3      in   3  instruction[14:12]
//   funct7b5    in   1  instruction[30]
//   Zero        in   1  ALU flag: operands equal
//   LT          in   1  ALU flag: signed less-than
//   LTU         in   1  ALU flag: unsigned less-than
//   MemReady    in   1  memory completes the current access this cycle
//   PCWrite     out  1  PC load enable
//   AdrSrc      out  1  memory address: 0 = PC, 1 = ALUOut
//   MemWrite    out  1  memory write enable
//   IRWrite     out  1  instruction register write enable
//   RegWrite    out  1  register file write enable
//   ResultSrc   out  2  00 ALUOut, 01 read data, 10 ALUResult
//   ALUSrcA     out  2  00 PC, 01 OldPC, 10 RD1, 11 zero
//   ALUSrcB     out  2  00 RD2, 01 ImmExt, 10 constant 4
//   ALUControl  out  4  ALU operation code
//   ImmSrc      out  3  immediate format, decoded from op in every state
//   Illegal     out  1  high while in TRAP
// ----------------------------------------------------------------------------
module multicycle_controller (
   input  logic       CLK,
   input  logic       Reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       LT,
   input  logic       LTU,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [3:0] ALUControl,
   output logic [2:0] ImmSrc,
   output logic       Illegal
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECUTER, S_EXECUTEI, S_ALUWB, S_JAL, S_JALR, S_JALRLINK,
      S_BRANCH, S_LUI, S_AUIPC, S_TRAP
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;

   state_t     r_state;
   state_t     w_next;
   logic       w_pcwrite;
   logic       w_memwrite;
   logic       w_irwrite;
   logic       w_regwrite;
   logic       w_illegal;

   // The immediate format ignores funct7b5 on I-type ops except for shifts,
   // so that addi/slti/... with immediate bit 10 set are not mistaken for sub.
   function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                             input logic       f7b5,
                                             input logic       is_rtype);
      logic [3:0] ctl;
      case (f3)
         3'b000:  ctl = (is_rtype && f7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  ctl = ALU_SLL;
         3'b010:  ctl = ALU_SLT;
         3'b011:  ctl = ALU_SLTU;
         3'b100:  ctl = ALU_XOR;
         3'b101:  ctl = f7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  ctl = ALU_OR;
         default: ctl = ALU_AND;
      endcase
      return ctl;
   endfunction

   // The funct3 values 010 and 011 never reach BRANCH because DECODE traps
   // them. They fall into the not-taken default here.
   function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                         input logic lt, input logic ltu);
      logic taken;
      case (f3)
         3'b000:  taken = z;
         3'b001:  taken = !z;
         3'b100:  taken = lt;
         3'b101:  taken = !lt;
         3'b110:  taken = ltu;
         3'b111:  taken = !ltu;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

   // NOTE: state registers use non-blocking assignment so that every flop
   // samples the pre-edge value of every other signal.
   always_ff @(posedge CLK) begin
      if (Reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   // NOTE: every signal gets a default at the top of this block. A path that
   // fails to assign one of them would otherwise infer a latch.
   always_comb begin
      w_next     = r_state;
      w_pcwrite  = 1'b0;
      w_memwrite = 1'b0;
      w_irwrite  = 1'b0;
      w_regwrite = 1'b0;
      w_illegal  = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = ALU_ADD;

      case (r_state)
         S_FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            w_pcwrite = MemReady;
            w_irwrite = MemReady;
            if (MemReady) w_next = S_DECODE;
         end
         S_DECODE: begin
            // The branch/jump target is precomputed into ALUOut here.
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (op)
               OP_LOAD, OP_STORE: w_next = (funct3 == 3'b010) ? S_MEMADR : S_TRAP;
               OP_RTYPE:  w_next = S_EXECUTER;
               OP_ITYPE:  w_next = S_EXECUTEI;
               OP_JAL:    w_next = S_JAL;
               OP_JALR:   w_next = (funct3 == 3'b000) ? S_JALR : S_TRAP;
               OP_BRANCH: w_next = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
               OP_LUI:    w_next = S_LUI;
               OP_AUIPC:  w_next = S_AUIPC;
               default:   w_next = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            // Bit 5 separates store (0100011) from load (0000011).
            w_next  = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
            if (MemReady) w_next = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc  = 2'b01;
            w_regwrite = 1'b1;
            w_next     = S_FETCH;
         end
         S_MEMWRITE: begin
            AdrSrc     = 1'b1;
            w_memwrite = 1'b1;
            if (MemReady) w_next = S_FETCH;
         end
         S_EXECUTER: begin
            ALUSrcA    = 2'b10;
            ALUControl = alu_decode(funct3, funct7b5, 1'b1);
            w_next     = S_ALUWB;
         end
         S_EXECUTEI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ALUControl = alu_decode(funct3, funct7b5, 1'b0);
            w_next     = S_ALUWB;
         end
         S_ALUWB: begin
            w_regwrite = 1'b1;
            w_next     = S_FETCH;
         end
         S_JAL: begin
            // The PC takes the target from ALUOut while the ALU forms OldPC+4
            // for the link write in ALUWB.
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            w_pcwrite = 1'b1;
            w_next    = S_ALUWB;
         end
         S_JALR: begin
            ALUSrcA   = 2'b10;
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            w_pcwrite = 1'b1;
            w_next    = S_JALRLINK;
         end
         S_JALRLINK: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            w_next  = S_ALUWB;
         end
         S_BRANCH: begin
            ALUSrcA    = 2'b10;
            ALUControl = ALU_SUB;
            w_pcwrite  = branch_taken(funct3, Zero, LT, LTU);
            w_next     = S_FETCH;
         end
         S_LUI: begin
            ALUSrcA = 2'b11;
            ALUSrcB = 2'b01;
            w_next  = S_ALUWB;
         end
         S_AUIPC: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            w_next  = S_ALUWB;
         end
         S_TRAP: begin
            w_illegal = 1'b1;
            w_next    = S_TRAP;
         end
         default: w_next = S_TRAP;
      endcase
   end

   always_comb begin
      case (op)
         OP_STORE:        ImmSrc = 3'b001;
         OP_BRANCH:       ImmSrc = 3'b010;
         OP_JAL:          ImmSrc = 3'b011;
         OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
         default:         ImmSrc = 3'b000;
      endcase
   end

   // Reset forces the architectural side effects off, whatever the state.
   assign PCWrite  = w_pcwrite  & ~Reset;
   assign MemWrite = w_memwrite & ~Reset;
   assign IRWrite  = w_irwrite  & ~Reset;
   assign RegWrite = w_regwrite & ~Reset;
   assign Illegal  = w_illegal  & ~Reset;

endmodule
